// File: rtl/beep_scheduler_if.sv
// Request/grant and tone signals between the sequencing logic and the buzzer scheduler.
interface beep_scheduler_if;
  logic        req_key;
  logic        req_door;
  logic        req_done;
  logic [2:0]  ack;
  logic        busy;
  logic        tone_en;
  logic [27:0] tone_div;
  logic        tone_out;

  modport master (
    output req_key, req_door, req_done,
    input  ack, busy, tone_en, tone_div, tone_out
  );

  modport slave (
    input  req_key, req_door, req_done,
    output ack, busy, tone_en, tone_div, tone_out
  );
endinterface

// File: rtl/beep_scheduler.sv
// Fixed-priority buzzer arbiter with beep-pattern sequencer and square-wave tone divider.
// Optional BEEP_MUTE_EN adds a mute input that silences tone_out without affecting timing.
module beep_scheduler #(
  parameter logic [27:0] DIV_KEY  = 28'd95556,
  parameter logic [27:0] DIV_DOOR = 28'd180505,
  parameter logic [27:0] DIV_DONE = 28'd361011,
  parameter logic [27:0] ON_CYC   = 28'd10000000,
  parameter logic [27:0] OFF_CYC  = 28'd5000000
) (
  input logic clock_in,
  input logic reset,
`ifdef BEEP_MUTE_EN
  input logic mute,
`endif
  beep_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t      state, state_n;
  logic [2:0]  pend, grant, ack_q;
  logic [1:0]  beeps_left;
  logic [27:0] phase_cnt, div_q, tone_cnt;
  logic        tone_q, busy_c, tone_en_c;
  logic        on_done, off_done;

  assign on_done  = (phase_cnt == ON_CYC - 28'd1);
  assign off_done = (phase_cnt == OFF_CYC - 28'd1);

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    grant   = 3'b000;
    case (state)
      IDLE: begin
        if (pend != 3'b000) begin
          state_n = ON;
          if (pend[2])      grant = 3'b100;
          else if (pend[1]) grant = 3'b010;
          else              grant = 3'b001;
        end
      end
      ON:      if (on_done) state_n = OFF;
      OFF:     if (off_done) state_n = (beeps_left != 2'd0) ? ON : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy_c    = (state != IDLE);
    tone_en_c = (state == ON);
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      pend       <= 3'b000;
      ack_q      <= 3'b000;
      div_q      <= 28'd0;
      beeps_left <= 2'd0;
      phase_cnt  <= 28'd0;
    end else begin
      // a new request in the grant cycle survives the clear and replays later
      pend  <= (pend & ~grant) | {bus.req_done, bus.req_door, bus.req_key};
      ack_q <= grant;
      if (grant != 3'b000) begin
        div_q      <= grant[2] ? DIV_DONE : (grant[1] ? DIV_DOOR : DIV_KEY);
        beeps_left <= grant[2] ? 2'd3 : (grant[1] ? 2'd2 : 2'd1);
        phase_cnt  <= 28'd0;
      end else if (state == ON) begin
        if (on_done) begin
          phase_cnt  <= 28'd0;
          beeps_left <= beeps_left - 2'd1;
        end else begin
          phase_cnt <= phase_cnt + 28'd1;
        end
      end else if (state == OFF) begin
        if (off_done) phase_cnt <= 28'd0;
        else          phase_cnt <= phase_cnt + 28'd1;
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      tone_cnt <= 28'd0;
      tone_q   <= 1'b0;
    end else if (tone_en_c) begin
      tone_q   <= (tone_cnt < (div_q >> 1));
      tone_cnt <= (tone_cnt >= div_q - 28'd1) ? 28'd0 : tone_cnt + 28'd1;
    end else begin
      tone_cnt <= 28'd0;
      tone_q   <= 1'b0;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.busy     = busy_c;
  assign bus.tone_en  = tone_en_c;
  assign bus.tone_div = div_q;
`ifdef BEEP_MUTE_EN
  assign bus.tone_out = tone_q & ~mute;
`else
  assign bus.tone_out = tone_q;
`endif

endmodule

// File: tb/tb_beep_scheduler.sv
// Directed bench for beep_scheduler with short phases and small divisors.
module tb_beep_scheduler;
  logic clock_in = 1'b0;
  logic reset    = 1'b1;
`ifdef BEEP_MUTE_EN
  logic mute     = 1'b0;
`endif
  int checks = 0;
  int errors = 0;

  beep_scheduler_if bus();

  beep_scheduler #(
    .DIV_KEY (28'd4),
    .DIV_DOOR(28'd6),
    .DIV_DONE(28'd8),
    .ON_CYC  (28'd4),
    .OFF_CYC (28'd2)
  ) dut (
    .clock_in(clock_in),
    .reset   (reset),
`ifdef BEEP_MUTE_EN
    .mute    (mute),
`endif
    .bus     (bus)
  );

  always #5 clock_in = ~clock_in;

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected tone_out in cycle j of a 6-cycle beep (j=0 first ON cycle, j=4,5 OFF)
  function automatic logic exp_tone(input int j, input int div);
    if (j >= 1 && j <= 4) return ((j - 1) % div) < (div / 2);
    return 1'b0;
  endfunction

  // entered in the grant cycle; leaves in the last OFF cycle of the pattern
  task automatic play(input int n, input int div, input logic [2:0] ack_exp, input bit inject);
    for (int b = 0; b < n; b++) begin
      for (int j = 0; j < 6; j++) begin
        if (!(b == 0 && j == 0)) tick();
        if (inject && b == 0 && j == 1) bus.req_door = 1'b0;
        chk("ack",      {29'd0, bus.ack}, {29'd0, (b == 0 && j == 0) ? ack_exp : 3'b000});
        chk("busy",     {31'd0, bus.busy}, 32'd1);
        chk("tone_en",  {31'd0, bus.tone_en}, {31'd0, (j < 4)});
        chk("tone_div", {4'd0, bus.tone_div}, div);
        chk("tone_out", {31'd0, bus.tone_out}, {31'd0, exp_tone(j, div)});
        if (inject && b == 0 && j == 0) bus.req_door = 1'b1;
      end
    end
  endtask

  task automatic idle_chk(input string tag);
    chk(tag, {28'd0, bus.busy, bus.ack}, 32'd0);
  endtask

  initial begin
    bus.req_key  = 1'b0;
    bus.req_door = 1'b0;
    bus.req_done = 1'b0;
    tick();
    tick();
    chk("rst_ack",      {29'd0, bus.ack}, 32'd0);
    chk("rst_busy",     {31'd0, bus.busy}, 32'd0);
    chk("rst_tone_en",  {31'd0, bus.tone_en}, 32'd0);
    chk("rst_tone_div", {4'd0, bus.tone_div}, 32'd0);
    chk("rst_tone_out", {31'd0, bus.tone_out}, 32'd0);
    reset = 1'b0;
    tick();
    idle_chk("idle_after_rst");

    // single key beep
    bus.req_key = 1'b1;
    tick();
    bus.req_key = 1'b0;
    idle_chk("key_pend_cycle");
    tick();
    play(1, 4, 3'b001, 0);
    tick();
    idle_chk("key_end");
    tick();
    idle_chk("key_quiet");

    // three-beep done alert; divisor held afterwards
    bus.req_done = 1'b1;
    tick();
    bus.req_done = 1'b0;
    tick();
    play(3, 8, 3'b100, 0);
    tick();
    idle_chk("done_end");
    chk("done_div_hold", {4'd0, bus.tone_div}, 32'd8);

    // simultaneous requests served by priority
    bus.req_key = 1'b1; bus.req_door = 1'b1; bus.req_done = 1'b1;
    tick();
    bus.req_key = 1'b0; bus.req_door = 1'b0; bus.req_done = 1'b0;
    tick();
    play(3, 8, 3'b100, 0);
    tick();
    idle_chk("sim_gap1");
    tick();
    play(2, 6, 3'b010, 0);
    tick();
    idle_chk("sim_gap2");
    tick();
    play(1, 4, 3'b001, 0);
    tick();
    idle_chk("sim_end");
    tick();
    idle_chk("sim_quiet");

    // door request while door plays replays once
    bus.req_door = 1'b1;
    tick();
    bus.req_door = 1'b0;
    tick();
    play(2, 6, 3'b010, 1);
    tick();
    idle_chk("door_gap");
    tick();
    play(2, 6, 3'b010, 0);
    tick();
    idle_chk("door_end");
    tick();
    idle_chk("door_quiet");

    // key request held across its own grant edge: set wins, replays
    bus.req_key = 1'b1;
    tick();
    tick();
    bus.req_key = 1'b0;
    play(1, 4, 3'b001, 0);
    tick();
    idle_chk("setwin_gap");
    tick();
    play(1, 4, 3'b001, 0);
    tick();
    idle_chk("setwin_end");
    tick();
    idle_chk("setwin_quiet");

    // reset during second ON phase of a done pattern
    bus.req_done = 1'b1;
    tick();
    bus.req_done = 1'b0;
    tick();
    chk("abort_grant", {29'd0, bus.ack}, 32'd4);
    for (int i = 0; i < 7; i++) tick();
    chk("abort_in_on", {31'd0, bus.tone_en}, 32'd1);
    chk("abort_tone",  {31'd0, bus.tone_out}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy",     {31'd0, bus.busy}, 32'd0);
    chk("abort_tone_en",  {31'd0, bus.tone_en}, 32'd0);
    chk("abort_tone_out", {31'd0, bus.tone_out}, 32'd0);
    chk("abort_tone_div", {4'd0, bus.tone_div}, 32'd0);
    chk("abort_ack",      {29'd0, bus.ack}, 32'd0);
    bus.req_key = 1'b1;
    tick();
    bus.req_key = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_chk("post_abort_idle");
    end
    chk("post_abort_div", {4'd0, bus.tone_div}, 32'd0);

`ifdef BEEP_MUTE_EN
    mute = 1'b1;
    bus.req_key = 1'b1;
    tick();
    bus.req_key = 1'b0;
    tick();
    for (int j = 0; j < 6; j++) begin
      if (j != 0) tick();
      chk("mute_busy",    {31'd0, bus.busy}, 32'd1);
      chk("mute_tone_en", {31'd0, bus.tone_en}, {31'd0, (j < 4)});
      chk("mute_tone",    {31'd0, bus.tone_out}, 32'd0);
    end
    tick();
    idle_chk("mute_end");
    mute = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/beep_scheduler.md
# beep_scheduler

- Shares the microwave's single buzzer tone path among three requesters:
  - keypad click
  - door alarm
  - cooking-done alert
- Arbitrates pending requests by fixed priority and sequences the winner's beep pattern (N beeps of ON/OFF phases).
- Drives a built-in square-wave tone divider using the winner's divisor.
- Sits between the control FSM / keypad logic and the buzzer pin, replacing free-running tone dividers.

## Interface

Parameters:
- DIV_KEY, 28'd95556, tone divisor for keypad beep (cycles per tone period).
- DIV_DOOR, 28'd180505, tone divisor for door alarm.
- DIV_DONE, 28'd361011, tone divisor for done alert.
- ON_CYC, 28'd10000000, clock cycles per beep ON phase (≥1).
- OFF_CYC, 28'd5000000, clock cycles per OFF phase (≥1).

Ports:
- clock_in, input, 1, system clock. One clock only.
- reset, input, 1, asynchronous, active-high reset.
- req_key, input, 1, single-cycle request pulse: 1 beep.
- req_door, input, 1, single-cycle request pulse: 2 beeps.
- req_done, input, 1, single-cycle request pulse: 3 beeps.
- ack, output, 3, one-hot grant pulse; one cycle wide; bit0 key, bit1 door, bit2 done.
- busy, output, 1, high whenever state ≠ IDLE.
- tone_en, output, 1, high during ON phases.
- tone_div, output, 28, divisor of the pattern currently granted.
- tone_out, output, 1, buzzer square wave.

## Operation

- Pending register `pend[2:0]`:
  - A request pulse sets its bit.
  - The bit clears on that source's grant.
  - Set and clear in the same cycle: set wins, so the source stays pending.
  - A request for the source currently playing is queued and replays afterwards.
- Priority: done > door > key. There is no preemption; a running pattern always completes.
- FSM states:
  - IDLE: if pend ≠ 0, grant the highest-priority pending source. On the grant:
    - pulse its ack bit;
    - load tone_div with its divisor;
    - load beeps_left = 1/2/3;
    - clear phase_cnt;
    - go to ON.
  - ON: tone_en = 1. When phase_cnt = ON_CYC−1, clear phase_cnt, decrement beeps_left, go to OFF.
  - OFF: tone_en = 0. When phase_cnt = OFF_CYC−1, clear phase_cnt; go to ON if beeps_left ≠ 0, else IDLE.
- The final OFF phase is a mandatory inter-pattern gap. Back-to-back patterns are always separated by OFF_CYC + 1 cycles of silence, the extra cycle being the IDLE grant cycle.
- Tone divider:
  - 28-bit counter runs only while tone_en = 1 and wraps at tone_div−1.
  - tone_out = (counter < tone_div/2), registered. Division is integer; for odd divisors the low half is the longer one.
  - While tone_en = 0, counter = 0 and tone_out = 0.
- tone_div holds its last value after IDLE is re-entered.
- Reset mid-pattern aborts immediately:
  - all outputs, pend, counters and FSM return to reset values;
  - requests asserted during reset are lost.

## Timing

- Reset values: ack = 0, busy = 0, tone_en = 0, tone_div = 0, tone_out = 0, FSM = IDLE, pend = 0.
- Request pulse at edge k (IDLE, nothing else pending):
  - pend set at edge k;
  - ack and busy high, and tone_en rises, after edge k+1;
  - ack falls after edge k+2.
- tone_en stays high exactly ON_CYC cycles per beep.
- tone_out first rises one cycle after tone_en rises, and lags tone_en's fall by one cycle.
- Pattern length from ack rising to busy falling: N·(ON_CYC + OFF_CYC) cycles.
- Simultaneous requests in one cycle:
  - served in priority order;
  - each subsequent grant occurs on the cycle after busy falls.

## Configuration

- Macro `BEEP_MUTE_EN`.
- Defined:
  - adds input port `mute` (1 bit);
  - while mute = 1, tone_out is forced to 0;
  - FSM, ack, busy, tone_en and tone_div are unaffected, so patterns still consume time.
- Undefined: no mute port; tone_out behaves as described above.

## Test plan

Bench parameters: ON_CYC = 4, OFF_CYC = 2, DIV_KEY = 4, DIV_DOOR = 6, DIV_DONE = 8.

- Reset, then one req_key pulse:
  - ack = 3'b001 for one cycle;
  - tone_div = 4;
  - tone_en high 4 cycles;
  - tone_out sequence 1,1,0,0;
  - busy high 6 cycles, then IDLE.
- req_done pulse:
  - three tone_en bursts of 4 cycles, each separated by 2 low cycles;
  - tone_div = 8;
  - busy high 18 cycles.
- req_key, req_door and req_done in the same cycle:
  - ack order 100, 010, 001;
  - each grant one cycle after busy falls;
  - total 3 + 2 + 1 beeps.
- req_door pulse while a door pattern is playing: after it completes, a second 2-beep door pattern follows with a new ack.
- Assert reset during the second ON phase of a done pattern: all outputs 0 asynchronously; after release, FSM is IDLE and no replay occurs.
- With BEEP_MUTE_EN and mute = 1 during req_key:
  - tone_out stays 0;
  - tone_en and busy timing identical to the unmuted case.
